i_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `i_cache_top`: it owns the program counter, issues word-address read requests to the instruction cache, retries on misses, and buffers returned instructions with their PCs in a small FIFO toward the decode stage. Branch/jump redirects from downstream flush the buffer and restart fetch at a new PC.

---
 rtl/i_fetch_pkg.sv | 20 ++
 rtl/i_fetch_unit_if.sv | 30 +++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/i_fetch_unit.sv | 109 ++++++++++
 tb/tb_i_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i_fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package i_fetch_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADD_WIDTH  = 12;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MISS_WAIT  = 2;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_RESP  = 2'd1,
    ST_MISS  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DEF_ADD_WIDTH-1:0]  pc;
    logic [DEF_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/i_fetch_unit_if.sv
// Fetch unit boundary: redirect input, i-cache request/response, decode-side instruction stream.
interface i_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 12,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  redirect_valid;
  logic [ADD_WIDTH-1:0]  redirect_pc;
  logic [ADD_WIDTH-1:0]  i_cache_addr;
  logic                  i_cache_rden;
  logic                  i_cache_hit_miss;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADD_WIDTH-1:0]  instr_pc;
  logic                  instr_ready;
  logic [CNT_W-1:0]      fifo_count;

  modport master (
    input  redirect_valid, redirect_pc, i_cache_hit_miss, cpu_data_out, instr_ready,
    output i_cache_addr, i_cache_rden, instr_valid, instr_data, instr_pc, fifo_count
  );

  modport slave (
    output redirect_valid, redirect_pc, i_cache_hit_miss, cpu_data_out, instr_ready,
    input  i_cache_addr, i_cache_rden, instr_valid, instr_data, instr_pc, fifo_count
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; wrapping pointers carry an extra MSB to tell full from empty.
// Latency: push visible at head the next cycle. Backpressure: push ignored when full, pop when empty.
// Head is gated to zero while empty so stale storage never leaks downstream.
module fetch_fifo import i_fetch_pkg::*; #(
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  T                       push_dat,
  input  logic                   pop_vld,
  output logic                   head_vld,
  output T                       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic        empty, full;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_vld && !full) begin
        mem_d[wptr_q[AW-1:0]] = push_dat;
        wptr_d                = wptr_q + 1'b1;
      end
      if (pop_vld && !empty) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    head_dat = '0;
    if (!empty) head_dat = mem_q[rptr_q[AW-1:0]];
  end

  assign head_vld = !empty;
  assign count    = wptr_q - rptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/i_fetch_unit.sv
// Instruction fetch: owns the PC, issues one i-cache read at a time, retries misses, buffers {pc, instr}.
// Latency: request to buffered instruction is 2 cycles on a hit; a miss costs 2+MISS_WAIT before retry.
// Backpressure: no request is issued unless a buffer slot is free, so responses are never dropped.
module i_fetch_unit import i_fetch_pkg::*; #(
  parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                  ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int                  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int                  MISS_WAIT  = DEF_MISS_WAIT,
  parameter logic [ADD_WIDTH-1:0] RESET_PC  = '0
) (
  input logic            clk,
  input logic            rst,
  i_fetch_unit_if.master bus
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MISS_WAIT + 1);

  typedef struct packed {
    logic [ADD_WIDTH-1:0]  pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_e         state_q, state_d;
  logic [ADD_WIDTH-1:0] pc_q, pc_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 rden, push_vld, pop_vld, flush, head_vld;
  logic [CNT_W-1:0]     count;
  entry_t               push_dat, head_dat;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wait_d   = wait_q;
    rden     = 1'b0;
    push_vld = 1'b0;
    flush    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // Slot check uses the registered count, so issue never depends on instr_ready.
        if (count < CNT_W'(FIFO_DEPTH)) begin
          rden    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.i_cache_hit_miss) begin
          push_vld = 1'b1;
          pc_d     = pc_q + 1'b1;
          state_d  = ST_FETCH;
        end else begin
          wait_d  = WAIT_W'(MISS_WAIT);
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WAIT_W'(1)) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Redirect wins over any in-flight response and drops the buffered stream.
    if (bus.redirect_valid) begin
      flush    = 1'b1;
      push_vld = 1'b0;
      rden     = 1'b0;
      pc_d     = bus.redirect_pc;
      wait_d   = '0;
      state_d  = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
    end
  end

  assign push_dat = '{pc: pc_q, instr: bus.cpu_data_out};
  assign pop_vld  = head_vld && bus.instr_ready && !bus.redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (count)
  );

  assign bus.i_cache_addr = pc_q;
  assign bus.i_cache_rden = rden && !rst;
  assign bus.instr_valid  = head_vld;
  assign bus.instr_data   = head_dat.instr;
  assign bus.instr_pc     = head_dat.pc;
  assign bus.fifo_count   = count;

endmodule

// File: tb/tb_i_fetch_unit.sv
// Bench for i_fetch_unit: plays the i-cache, drives decode/redirect, checks against a queue-based model.
module tb_i_fetch_unit;
  import i_fetch_pkg::*;

  localparam int         DW    = 32;
  localparam int         AW    = 12;
  localparam int         DEPTH = 4;
  localparam int         MW    = 2;
  localparam logic [11:0] RPC  = 12'h000;

  typedef struct packed {
    logic        rden;
    logic [11:0] addr;
    logic        vld;
    logic [11:0] pc;
    logic [31:0] data;
    logic [2:0]  cnt;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i_fetch_unit_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  i_fetch_unit #(
    .DATA_WIDTH (DW),
    .ADD_WIDTH  (AW),
    .FIFO_DEPTH (DEPTH),
    .MISS_WAIT  (MW),
    .RESET_PC   (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: buffered stream as queues, one outstanding request, miss stall countdown.
  logic [11:0] mq_pc   [$];
  logic [31:0] mq_data [$];
  logic [11:0] m_pc    = RPC;
  bit          m_out   = 1'b0;
  int          m_stall = 0;
  logic [11:0] c_addr  = '0;

  snap_t dut_s, ref_s;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {~a, 8'hC3, a};
  endfunction

  task automatic tick(input logic r, input logic rdy, input logic redir,
                      input logic [11:0] rpc, input logic hit);
    bit do_pop;
    @(negedge clk);
    rst                  = r;
    bus.instr_ready      = rdy;
    bus.redirect_valid   = redir;
    bus.redirect_pc      = rpc;
    bus.i_cache_hit_miss = hit;
    bus.cpu_data_out     = hit ? mem_word(c_addr) : $urandom;
    #1;
    dut_s.rden = bus.i_cache_rden;
    dut_s.addr = bus.i_cache_addr;
    dut_s.vld  = bus.instr_valid;
    dut_s.pc   = bus.instr_pc;
    dut_s.data = bus.instr_data;
    dut_s.cnt  = bus.fifo_count;
    ref_s.rden = !r && !redir && !m_out && (m_stall == 0) && (mq_pc.size() < DEPTH);
    ref_s.addr = m_pc;
    ref_s.vld  = (mq_pc.size() > 0);
    ref_s.pc   = ref_s.vld ? mq_pc[0] : 12'h000;
    ref_s.data = ref_s.vld ? mq_data[0] : 32'h0;
    ref_s.cnt  = 3'(mq_pc.size());
    if (!ref_s.vld) begin
      dut_s.pc   = '0;
      dut_s.data = '0;
    end
    if (bus.i_cache_rden) c_addr = bus.i_cache_addr;
    if (r) begin
      mq_pc.delete(); mq_data.delete();
      m_pc = RPC; m_out = 1'b0; m_stall = 0;
    end else if (redir) begin
      mq_pc.delete(); mq_data.delete();
      m_pc = rpc; m_out = 1'b0; m_stall = 0;
    end else begin
      do_pop = ref_s.vld && rdy;
      if (do_pop) begin
        void'(mq_pc.pop_front());
        void'(mq_data.pop_front());
      end
      if (m_out) begin
        if (hit) begin
          mq_pc.push_back(m_pc);
          mq_data.push_back(mem_word(m_pc));
          m_pc = m_pc + 12'h001;
        end else begin
          m_stall = MW;
        end
        m_out = 1'b0;
      end else if (m_stall > 0) begin
        m_stall--;
      end
      if (ref_s.rden) m_out = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, 12'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 12'h0, 1'b1);
    total++; if (bus.i_cache_rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b want=0", bus.i_cache_rden); end
    total++; if (bus.i_cache_addr !== RPC) begin bad++; $display("FAIL reset_addr got=%h want=%h", bus.i_cache_addr, RPC); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
    total++; if ({bus.instr_valid, bus.instr_pc, bus.instr_data} !== 45'h0) begin
      bad++; $display("FAIL reset_head got vld=%b pc=%h data=%h want all zero", bus.instr_valid, bus.instr_pc, bus.instr_data);
    end
  endtask

  task automatic test_all_hits();
    snap_t s [8];
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b1, 1'b0, 12'h0, 1'b1);
      s[k] = dut_s;
      total++; if (dut_s !== ref_s) begin bad++; $display("FAIL hits_cyc%0d got=%h want=%h", k, dut_s, ref_s); end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (s[2*k].rden !== 1'b1 || s[2*k].addr !== 12'(k) || s[2*k+1].rden !== 1'b0) begin
        bad++; $display("FAIL hits_issue%0d got rden=%b/%b addr=%h want 1/0 %h", k, s[2*k].rden, s[2*k+1].rden, s[2*k].addr, 12'(k));
      end
    end
    total++;
    if (s[2].vld !== 1'b1 || s[2].pc !== 12'h000 || s[2].data !== mem_word(12'h000)) begin
      bad++; $display("FAIL hits_first vld=%b pc=%h data=%h want 1 000 %h", s[2].vld, s[2].pc, s[2].data, mem_word(12'h000));
    end
  endtask

  task automatic test_redirect_miss();
    logic  hits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    snap_t s [8];
    tick(1'b0, 1'b1, 1'b1, 12'hABC, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 1'b1, 1'b0, 12'h0, hits[k]);
      s[k] = dut_s;
      total++; if (dut_s !== ref_s) begin bad++; $display("FAIL rmiss_cyc%0d got=%h want=%h", k, dut_s, ref_s); end
    end
    total++;
    if (s[0].rden !== 1'b1 || s[0].addr !== 12'hABC || s[2].rden !== 1'b0 || s[3].rden !== 1'b0) begin
      bad++; $display("FAIL rmiss_wait got rden=%b%b%b addr=%h want 100 abc", s[0].rden, s[2].rden, s[3].rden, s[0].addr);
    end
    total++;
    if (s[4].rden !== 1'b1 || s[4].addr !== 12'hABC) begin
      bad++; $display("FAIL rmiss_retry got rden=%b addr=%h want 1 abc", s[4].rden, s[4].addr);
    end
    total++;
    if (s[6].vld !== 1'b1 || s[6].pc !== 12'hABC || s[6].data !== mem_word(12'hABC)) begin
      bad++; $display("FAIL rmiss_entry got vld=%b pc=%h data=%h want 1 abc %h", s[6].vld, s[6].pc, s[6].data, mem_word(12'hABC));
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do begin
      tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
      total++; if (dut_s !== ref_s) begin bad++; $display("FAIL bp_fill%0d got=%h want=%h", n, dut_s, ref_s); end
      n++;
    end while (dut_s.cnt !== 3'd4 && n < 20);
    total++; if (n >= 20) begin bad++; $display("FAIL bp_timeout count=%0d want 4", dut_s.cnt); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
      total++;
      if (dut_s.rden !== 1'b0 || dut_s.cnt !== 3'd4) begin
        bad++; $display("FAIL bp_hold%0d got rden=%b cnt=%0d want 0 4", k, dut_s.rden, dut_s.cnt);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 12'h0, 1'b1);
    total++; if (dut_s.rden !== 1'b0) begin bad++; $display("FAIL bp_pop_same got rden=%b want 0", dut_s.rden); end
    tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
    total++; if (dut_s.rden !== 1'b1 || dut_s.cnt !== 3'd3) begin
      bad++; $display("FAIL bp_reissue got rden=%b cnt=%0d want 1 3", dut_s.rden, dut_s.cnt);
    end
    tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
    total++; if (dut_s !== ref_s || dut_s.cnt !== 3'd4) begin
      bad++; $display("FAIL bp_refill got=%h want=%h", dut_s, ref_s);
    end
  endtask

  task automatic test_redirect_resp();
    int n = 0;
    tick(1'b0, 1'b1, 1'b0, 12'h0, 1'b1);
    do begin
      tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
      n++;
    end while (dut_s.rden !== 1'b1 && n < 10);
    total++; if (n >= 10 || dut_s.cnt !== 3'd3) begin
      bad++; $display("FAIL rresp_setup got rden=%b cnt=%0d want 1 3", dut_s.rden, dut_s.cnt);
    end
    tick(1'b0, 1'b1, 1'b1, 12'h203, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
    total++;
    if (dut_s.cnt !== 3'd0 || dut_s.vld !== 1'b0 || dut_s.rden !== 1'b1 || dut_s.addr !== 12'h203) begin
      bad++; $display("FAIL rresp_after got cnt=%0d vld=%b rden=%b addr=%h want 0 0 1 203", dut_s.cnt, dut_s.vld, dut_s.rden, dut_s.addr);
    end
  endtask

  task automatic test_wrap();
    snap_t s [6];
    tick(1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b1, 1'b0, 12'h0, 1'b1);
      s[k] = dut_s;
      total++; if (dut_s !== ref_s) begin bad++; $display("FAIL wrap_cyc%0d got=%h want=%h", k, dut_s, ref_s); end
    end
    total++;
    if (s[0].addr !== 12'hFFF || s[2].rden !== 1'b1 || s[2].addr !== 12'h000) begin
      bad++; $display("FAIL wrap_addr got %h then %h want fff then 000", s[0].addr, s[2].addr);
    end
    total++;
    if (s[2].pc !== 12'hFFF || s[4].vld !== 1'b1 || s[4].pc !== 12'h000 || s[4].data !== mem_word(12'h000)) begin
      bad++; $display("FAIL wrap_entries got pc %h then %h want fff then 000", s[2].pc, s[4].pc);
    end
  endtask

  task automatic test_reset_mid_miss();
    int n = 0;
    tick(1'b0, 1'b0, 1'b1, 12'h100, 1'b1);
    do begin
      tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
      n++;
    end while (!(dut_s.cnt === 3'd2 && dut_s.rden === 1'b1) && n < 20);
    total++; if (n >= 20) begin bad++; $display("FAIL rstmiss_setup got cnt=%0d rden=%b want 2 1", dut_s.cnt, dut_s.rden); end
    tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 12'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 12'h0, 1'b1);
    total++;
    if (dut_s.cnt !== 3'd0 || dut_s.rden !== 1'b0 || dut_s.addr !== RPC) begin
      bad++; $display("FAIL rstmiss_state got cnt=%0d rden=%b addr=%h want 0 0 %h", dut_s.cnt, dut_s.rden, dut_s.addr, RPC);
    end
    tick(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
    total++;
    if (dut_s.rden !== 1'b1 || dut_s.addr !== RPC) begin
      bad++; $display("FAIL rstmiss_restart got rden=%b addr=%h want 1 %h", dut_s.rden, dut_s.addr, RPC);
    end
  endtask

  task automatic test_random();
    logic r, rdy, redir, hit;
    logic [11:0] rpc;
    for (int k = 0; k < 600; k++) begin
      r     = ($urandom_range(99) < 1);
      rdy   = ($urandom_range(99) < 70);
      redir = ($urandom_range(99) < 4);
      hit   = ($urandom_range(99) < 70);
      rpc   = 12'($urandom);
      tick(r, rdy, redir, rpc, hit);
      total++; if (dut_s !== ref_s) begin bad++; $display("FAIL rand_cyc%0d got=%h want=%h", k, dut_s, ref_s); end
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.instr_ready      = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = '0;
    bus.i_cache_hit_miss = 1'b0;
    bus.cpu_data_out     = '0;
    test_reset();
    test_all_hits();
    test_redirect_miss();
    test_backpressure();
    test_redirect_resp();
    test_wrap();
    test_reset_mid_miss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
